// File: rtl/mul_pipe_pgc_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_pgc_if
// Brief    : Issue/result bundle for the Int0 pipelined multiplier.
// Revision : 1.0
// ============================================================================
interface mul_pipe_pgc_if;
  logic        mul_req;
  logic        mul_rdy;
  logic [31:0] mul_src_a;
  logic [31:0] mul_src_b;
  logic        mul_signed;
  logic [11:0] mul_tag;
  logic        mul_flush;
  logic [31:0] mul_rslt;
  logic [1:0]  mul_rslt_cc;
  logic [11:0] mul_rslt_tag;
  logic        mul_rslt_vld;
  logic        pg_mul;

  modport master (
    output mul_req, mul_src_a, mul_src_b, mul_signed, mul_tag, mul_flush,
    input  mul_rdy, mul_rslt, mul_rslt_cc, mul_rslt_tag, mul_rslt_vld, pg_mul
  );

  modport slave (
    input  mul_req, mul_src_a, mul_src_b, mul_signed, mul_tag, mul_flush,
    output mul_rdy, mul_rslt, mul_rslt_cc, mul_rslt_tag, mul_rslt_vld, pg_mul
  );
endinterface
`default_nettype wire

// File: rtl/mul_pipe_pgc.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_pgc
// Brief    : 3-stage 32x32 multiplier with idle power-gating controller.
// Revision : 1.0
// ============================================================================
module mul_pipe_pgc #(
  parameter int LAT      = 3,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_pipe_pgc_if.slave mul
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

  generate
    if (LAT != 3 || IDLE_CYC < 1 || IDLE_CYC > 255 || WAKE_CYC < 1 || WAKE_CYC > 15) begin : g_param_chk
      $error("mul_pipe_pgc: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  idle_cnt, idle_cnt_nxt;
  logic [3:0]  wake_cnt, wake_cnt_nxt;

  logic        rdy, accept, busy, idle;

  logic        s1_vld;
  logic [32:0] s1_a, s1_b;
  logic [11:0] s1_tag;

  logic        s2_vld;
  logic [31:0] pp_ll;
  logic [33:0] pp_lh, pp_hl, pp_hh;
  logic [11:0] s2_tag;

  logic        s3_vld;
  logic [31:0] rslt;
  logic [1:0]  rslt_cc;
  logic [11:0] rslt_tag;

  logic [33:0] a_lo, a_hi, b_lo, b_hi;
  logic [63:0] prod;
  logic [31:0] prod_hi_unused;

  assign rdy    = rst_n & (state == ST_ON) & ~mul.mul_flush;
  assign accept = mul.mul_req & rdy;
  assign busy   = s1_vld | s2_vld | s3_vld;
  // A flush empties the pipe at the coming edge, so it may count as idle.
  assign idle   = ~accept & (mul.mul_flush | ~busy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      idle_cnt <= '0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    case (state)
      ST_OFF: begin
        idle_cnt_nxt = '0;
        if (mul.mul_req && !mul.mul_flush) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nxt    = ST_ON;
          wake_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt + 4'd1;
        end
      end
      ST_ON: begin
        if (!idle) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt    = ST_OFF;
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  // 33-bit operands split as unsigned low 16 and signed high 17 bits.
  assign a_lo = {18'h0, s1_a[15:0]};
  assign b_lo = {18'h0, s1_b[15:0]};
  assign a_hi = {{17{s1_a[32]}}, s1_a[32:16]};
  assign b_hi = {{17{s1_b[32]}}, s1_b[32:16]};

  assign prod = {32'h0, pp_ll}
              + ({{30{pp_lh[33]}}, pp_lh} << 16)
              + ({{30{pp_hl[33]}}, pp_hl} << 16)
              + ({{30{pp_hh[33]}}, pp_hh} << 32);
  assign prod_hi_unused = prod[63:32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s2_vld   <= 1'b0;
      pp_ll    <= '0;
      pp_lh    <= '0;
      pp_hl    <= '0;
      pp_hh    <= '0;
      s2_tag   <= '0;
      s3_vld   <= 1'b0;
      rslt     <= '0;
      rslt_cc  <= '0;
      rslt_tag <= '0;
    end else begin
      s1_vld <= accept;
      s2_vld <= s1_vld & ~mul.mul_flush;
      s3_vld <= s2_vld & ~mul.mul_flush;
      if (accept) begin
        s1_a   <= {mul.mul_signed & mul.mul_src_a[31], mul.mul_src_a};
        s1_b   <= {mul.mul_signed & mul.mul_src_b[31], mul.mul_src_b};
        s1_tag <= mul.mul_tag;
      end
      if (s1_vld) begin
        pp_ll  <= {16'h0, s1_a[15:0]} * {16'h0, s1_b[15:0]};
        pp_lh  <= a_lo * b_hi;
        pp_hl  <= a_hi * b_lo;
        pp_hh  <= a_hi * b_hi;
        s2_tag <= s1_tag;
      end
      if (s2_vld && !mul.mul_flush) begin
        rslt     <= prod[31:0];
        rslt_cc  <= {prod[31], (prod[31:0] == 32'h0)};
        rslt_tag <= s2_tag;
      end
    end
  end

  assign mul.mul_rdy      = rdy;
  assign mul.mul_rslt     = rslt;
  assign mul.mul_rslt_cc  = rslt_cc;
  assign mul.mul_rslt_tag = rslt_tag;
  assign mul.mul_rslt_vld = s3_vld;
  assign mul.pg_mul       = (state == ST_ON);

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_pgc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_pipe_pgc
// Brief    : Self-checking bench for mul_pipe_pgc (directed + random).
// Revision : 1.0
// ============================================================================
module tb_mul_pipe_pgc;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mul_pipe_pgc_if bus ();

  mul_pipe_pgc #(.LAT(3), .IDLE_CYC(16), .WAKE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mul   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [11:0] tag;
    int          cyc;
  } op_t;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint pa, pb;
    if (sg) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'h0, a});
      pb = longint'({32'h0, b});
    end
    return 32'(pa * pb);
  endfunction

  function automatic logic [1:0] ref_cc(input logic [31:0] r);
    return {r[31], (r == 32'h0)};
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic [11:0] tag);
    bus.mul_req    = 1'b1;
    bus.mul_src_a  = a;
    bus.mul_src_b  = b;
    bus.mul_signed = sg;
    bus.mul_tag    = tag;
  endtask

  // Bring the unit to ON without issuing an operation.
  task automatic go_on();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      bus.mul_flush = 1'b0;
      if (bus.pg_mul === 1'b1) begin
        bus.mul_req = 1'b0;
        ok = 1'b1;
      end else begin
        drive_op(32'h0, 32'h0, 1'b0, 12'h0);
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL go_on: pg_mul=%b, required 1 within 30 cycles", bus.pg_mul);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mul_req = 1'b0; bus.mul_flush = 1'b0;
    bus.mul_src_a = '0; bus.mul_src_b = '0; bus.mul_signed = 1'b0; bus.mul_tag = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.mul_rslt !== 32'h0 || bus.mul_rslt_cc !== 2'b00 || bus.mul_rslt_tag !== 12'h0) begin
      fails++;
      $display("FAIL reset_data: rslt=%h cc=%b tag=%h, required 0", bus.mul_rslt, bus.mul_rslt_cc, bus.mul_rslt_tag);
    end
    tests++;
    if (bus.mul_rslt_vld !== 1'b0 || bus.pg_mul !== 1'b0 || bus.mul_rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: vld=%b pg=%b rdy=%b, required 000", bus.mul_rslt_vld, bus.pg_mul, bus.mul_rdy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.mul_rdy !== 1'b0 || bus.pg_mul !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_cycle: rdy=%b pg=%b, required 0 0", bus.mul_rdy, bus.pg_mul);
    end
  endtask

  task automatic test_wake();
    logic exp_on;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      drive_op(32'd7, 32'd6, 1'b0, 12'h0A5);
      #1;
      exp_on = (k == 5);
      tests++;
      if (bus.mul_rdy !== exp_on || bus.pg_mul !== exp_on) begin
        fails++;
        $display("FAIL wake_cycle%0d: rdy=%b pg=%b, required %b %b", k, bus.mul_rdy, bus.pg_mul, exp_on, exp_on);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.mul_req = 1'b0;
      tests++;
      if (bus.mul_rslt_vld !== (i == 3)) begin
        fails++;
        $display("FAIL wake_vld%0d: vld=%b, required %b", i, bus.mul_rslt_vld, (i == 3));
      end
      if (i >= 3) begin
        tests++;
        if (bus.mul_rslt !== 32'd42 || bus.mul_rslt_cc !== 2'b00 || bus.mul_rslt_tag !== 12'h0A5 || bus.pg_mul !== 1'b1) begin
          fails++;
          $display("FAIL wake_result%0d: rslt=%h cc=%b tag=%h pg=%b, required 2a 00 0a5 1",
                   i, bus.mul_rslt, bus.mul_rslt_cc, bus.mul_rslt_tag, bus.pg_mul);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic        os [3];
    logic [31:0] er [3];
    logic [1:0]  ec [3];
    oa = '{32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFD};
    ob = '{32'hFFFFFFFF, 32'h00010000, 32'h00000005};
    os = '{1'b1, 1'b0, 1'b1};
    er = '{32'h00000001, 32'h00000000, 32'hFFFFFFF1};
    ec = '{2'b00, 2'b01, 2'b10};
    go_on();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i < 3) drive_op(oa[i], ob[i], os[i], 12'h101 + 12'(i));
      else       bus.mul_req = 1'b0;
      #1;
      if (i < 3) begin
        tests++;
        if (bus.mul_rdy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_rdy%0d: rdy=%b, required 1", i, bus.mul_rdy);
        end
      end
      tests++;
      if (bus.mul_rslt_vld !== (i >= 3 && i < 6)) begin
        fails++;
        $display("FAIL b2b_vld%0d: vld=%b, required %b", i, bus.mul_rslt_vld, (i >= 3 && i < 6));
      end
      if (i >= 3 && i < 6) begin
        tests++;
        if (bus.mul_rslt !== er[i-3] || bus.mul_rslt_cc !== ec[i-3] || bus.mul_rslt_tag !== 12'h101 + 12'(i-3)) begin
          fails++;
          $display("FAIL b2b_result%0d: rslt=%h cc=%b tag=%h, required %h %b %h",
                   i-3, bus.mul_rslt, bus.mul_rslt_cc, bus.mul_rslt_tag, er[i-3], ec[i-3], 12'h101 + 12'(i-3));
        end
      end
    end
  endtask

  task automatic test_idle_power_down();
    go_on();
    @(negedge clk);
    drive_op(32'd3, 32'd5, 1'b0, 12'h111);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.mul_req = 1'b0;
      #1;
      if (i == 3) begin
        tests++;
        if (bus.mul_rslt_vld !== 1'b1 || bus.mul_rslt !== 32'd15 || bus.mul_rslt_tag !== 12'h111) begin
          fails++;
          $display("FAIL idle_result: vld=%b rslt=%h tag=%h, required 1 f 111", bus.mul_rslt_vld, bus.mul_rslt, bus.mul_rslt_tag);
        end
      end
      tests++;
      if (bus.pg_mul !== (i < 20)) begin
        fails++;
        $display("FAIL idle_pg%0d: pg=%b, required %b", i, bus.pg_mul, (i < 20));
      end
    end
    tests++;
    if (bus.mul_rdy !== 1'b0) begin
      fails++;
      $display("FAIL idle_off_rdy: rdy=%b, required 0", bus.mul_rdy);
    end
    // Second pass: a request on the final idle cycle keeps the unit on.
    go_on();
    @(negedge clk);
    drive_op(32'd4, 32'd4, 1'b0, 12'h112);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 19) drive_op(32'd9, 32'd9, 1'b0, 12'h113);
      else         bus.mul_req = 1'b0;
      #1;
      if (i == 19) begin
        tests++;
        if (bus.mul_rdy !== 1'b1) begin
          fails++;
          $display("FAIL idle_last_rdy: rdy=%b, required 1", bus.mul_rdy);
        end
      end
      if (i >= 19) begin
        tests++;
        if (bus.pg_mul !== 1'b1) begin
          fails++;
          $display("FAIL idle_keep_on%0d: pg=%b, required 1", i, bus.pg_mul);
        end
      end
    end
    tests++;
    if (bus.mul_rslt_vld !== 1'b1 || bus.mul_rslt !== 32'd81 || bus.mul_rslt_tag !== 12'h113) begin
      fails++;
      $display("FAIL idle_keep_result: vld=%b rslt=%h tag=%h, required 1 51 113", bus.mul_rslt_vld, bus.mul_rslt, bus.mul_rslt_tag);
    end
  endtask

  task automatic test_flush();
    logic exp_vld;
    go_on();
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      bus.mul_flush = (i == 3);
      if (i < 3)       drive_op(32'(i + 2), 32'd10, 1'b0, 12'h201 + 12'(i));
      else if (i < 5)  drive_op(32'd11, 32'd11, 1'b0, 12'h204);
      else             bus.mul_req = 1'b0;
      #1;
      if (i == 3 || i == 4) begin
        tests++;
        if (bus.mul_rdy !== (i == 4)) begin
          fails++;
          $display("FAIL flush_rdy%0d: rdy=%b, required %b", i, bus.mul_rdy, (i == 4));
        end
      end
      // op 0x201 had already reached the output register when flush rose.
      exp_vld = (i == 3 || i == 7);
      tests++;
      if (bus.mul_rslt_vld !== exp_vld) begin
        fails++;
        $display("FAIL flush_vld%0d: vld=%b, required %b", i, bus.mul_rslt_vld, exp_vld);
      end
      if (i == 7) begin
        tests++;
        if (bus.mul_rslt !== 32'd121 || bus.mul_rslt_tag !== 12'h204) begin
          fails++;
          $display("FAIL flush_new_op: rslt=%h tag=%h, required 79 204", bus.mul_rslt, bus.mul_rslt_tag);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    go_on();
    @(negedge clk);
    drive_op(32'd5, 32'd5, 1'b0, 12'h301);
    @(negedge clk);
    drive_op(32'd6, 32'd6, 1'b0, 12'h302);
    @(negedge clk);
    bus.mul_req = 1'b0;
    rst_n = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) rst_n = 1'b1;
      #1;
      tests++;
      if (bus.mul_rslt_vld !== 1'b0 || bus.pg_mul !== 1'b0 || bus.mul_rdy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_ctrl%0d: vld=%b pg=%b rdy=%b, required 000", i, bus.mul_rslt_vld, bus.pg_mul, bus.mul_rdy);
      end
      tests++;
      if (bus.mul_rslt !== 32'h0 || bus.mul_rslt_cc !== 2'b00 || bus.mul_rslt_tag !== 12'h0) begin
        fails++;
        $display("FAIL rstmid_data%0d: rslt=%h cc=%b tag=%h, required 0", i, bus.mul_rslt, bus.mul_rslt_cc, bus.mul_rslt_tag);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_random();
    op_t         q[$];
    op_t         e;
    op_t         cur;
    bit          have_op = 1'b0;
    int          gap = 0;
    int          done = 0;
    logic [31:0] er;
    cur = '{a: 32'h0, b: 32'h0, sg: 1'b0, tag: 12'h0, cyc: 0};
    for (int cyc = 0; cyc < 712; cyc++) begin
      @(negedge clk);
      if (bus.mul_rslt_vld === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_extra_vld: vld=1 tag=%h, required no completion", bus.mul_rslt_tag);
        end else begin
          e  = q.pop_front();
          er = ref_mul(e.a, e.b, e.sg);
          done++;
          if (bus.mul_rslt !== er || bus.mul_rslt_cc !== ref_cc(er) || bus.mul_rslt_tag !== e.tag) begin
            fails++;
            $display("FAIL rand_result: rslt=%h cc=%b tag=%h, required %h %b %h (a=%h b=%h s=%b)",
                     bus.mul_rslt, bus.mul_rslt_cc, bus.mul_rslt_tag, er, ref_cc(er), e.tag, e.a, e.b, e.sg);
          end
          tests++;
          if (bus.pg_mul !== 1'b1 || cyc != e.cyc + 3) begin
            fails++;
            $display("FAIL rand_timing: pg=%b cycle=%0d, required pg 1 cycle %0d", bus.pg_mul, cyc, e.cyc + 3);
          end
        end
      end
      if (cyc < 700 && !have_op) begin
        if (gap > 0) begin
          gap--;
        end else if ($urandom_range(0, 99) < 4) begin
          gap = int'($urandom_range(15, 30));
        end else if ($urandom_range(0, 99) < 65) begin
          cur.a   = pick_operand();
          cur.b   = pick_operand();
          cur.sg  = 1'($urandom_range(0, 1));
          cur.tag = 12'($urandom);
          have_op = 1'b1;
        end
      end
      bus.mul_flush = 1'b0;
      if (have_op) drive_op(cur.a, cur.b, cur.sg, cur.tag);
      else         bus.mul_req = 1'b0;
      #1;
      if (bus.mul_req && bus.mul_rdy === 1'b1) begin
        cur.cyc = cyc;
        q.push_back(cur);
        have_op = 1'b0;
      end
    end
    bus.mul_req = 1'b0;
    tests++;
    if (q.size() != 0 || done < 50) begin
      fails++;
      $display("FAIL rand_drain: pending=%0d completed=%0d, required 0 pending and >=50 completed", q.size(), done);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wake();
    test_back_to_back();
    test_idle_power_down();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
